// File: rtl/ex_pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// ex_pipe_stage_skid_pkg
// Shared definitions for the EX->MEM pipeline stage with skid buffer:
//   - FSM state encoding (EMPTY / ONE / FULL)
//   - occupancy counter width
//   - helper to turn the two entry valid bits into an entry count
// ---------------------------------------------------------------------------
package ex_pipe_stage_skid_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int unsigned OCC_WIDTH = 2;

   typedef enum logic [1:0] {
      StEmpty = ST_EMPTY,
      StOne   = ST_ONE,
      StFull  = ST_FULL
   } skid_state_e;

   // Number of occupied entries; two 1-bit terms cannot wrap a 2-bit sum.
   function automatic logic [OCC_WIDTH-1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/ex_pipe_stage_skid_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One storage entry of the skid pipeline: NrOfBits payload plus a valid bit.
// Ports:
//   Clock     in   clock, all updates on posedge
//   clear     in   sync clear: data <= ResetValue, valid <= 0 (wins over writes)
//   data_we   in   load data_in into the payload
//   data_in   in   payload to load
//   valid_we  in   load valid_in into the valid bit
//   valid_in  in   valid bit to load
//   data      out  stored payload
//   valid     out  stored valid bit
// Payload and valid have separate write enables so an entry can be
// invalidated without disturbing its payload.
// ---------------------------------------------------------------------------
module pipe_entry_reg
   import ex_pipe_stage_skid_pkg::*;
#(
   parameter int unsigned          NrOfBits   = 32,
   parameter logic [NrOfBits-1:0]  ResetValue = '0
) (
   input  logic                Clock,
   input  logic                clear,
   input  logic                data_we,
   input  logic [NrOfBits-1:0] data_in,
   input  logic                valid_we,
   input  logic                valid_in,
   output logic [NrOfBits-1:0] data,
   output logic                valid
);

   logic [NrOfBits-1:0] data_q;
   logic                valid_q;

   always_ff @(posedge Clock) begin
      if (clear) begin
         data_q  <= ResetValue;
         valid_q <= 1'b0;
      end else begin
         if (data_we) begin
            data_q <= data_in;
         end
         if (valid_we) begin
            valid_q <= valid_in;
         end
      end
   end

   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/ex_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// ex_pipe_stage_skid
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer (main entry drives the output, skid entry catches the word that
// arrives while the downstream stalls). in_ready is a flop, so there is no
// combinational ready path back to the upstream stage.
// Ports:
//   Clock        in   clock
//   Reset        in   sync active-high reset, highest priority
//   ClockEnable  in   stall control; advance = ClockEnable & Tick
//   Tick         in   global tick qualifier
//   flush        in   sync clear of both entries
//   pre          in   load PresetValue into main entry (valid), drop skid
//   cs           in   1 = output disabled (out_valid=0, out_data=0)
//   in_valid     in   upstream valid
//   in_data      in   upstream payload
//   in_ready     out  registered: skid entry empty
//   out_valid    out  main entry valid and output enabled
//   out_data     out  main payload, 0 when cs=1
//   out_ready    in   downstream accepts
//   occupancy    out  entries held (0..2)
// ---------------------------------------------------------------------------
module ex_pipe_stage_skid
   import ex_pipe_stage_skid_pkg::*;
#(
   parameter int unsigned          NrOfBits    = 32,
   parameter logic [NrOfBits-1:0]  ResetValue  = '0,
   parameter logic [NrOfBits-1:0]  PresetValue = '1
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 ClockEnable,
   input  logic                 Tick,
   input  logic                 flush,
   input  logic                 pre,
   input  logic                 cs,
   input  logic                 in_valid,
   input  logic [NrOfBits-1:0]  in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [NrOfBits-1:0]  out_data,
   input  logic                 out_ready,
   output logic [OCC_WIDTH-1:0] occupancy
);

   skid_state_e state_q, state_d;
   logic        in_ready_q, in_ready_d;

   logic                entry_clear;
   logic                main_data_we, main_valid_we, main_valid_in;
   logic [NrOfBits-1:0] main_data_in;
   logic                skid_data_we, skid_valid_we, skid_valid_in;
   logic [NrOfBits-1:0] main_data, skid_data;
   logic                main_valid, skid_valid;

   logic advance, in_xfer, out_xfer;

   assign advance  = ClockEnable & Tick;
   assign in_xfer  = advance & in_valid & in_ready_q;
   // out_valid already folds in cs, so a disabled output never transfers.
   assign out_xfer = advance & out_valid & out_ready;

   assign entry_clear = Reset | flush;

   always_comb begin
      main_data_we  = 1'b0;
      main_data_in  = in_data;
      main_valid_we = 1'b0;
      main_valid_in = 1'b0;
      skid_data_we  = 1'b0;
      skid_valid_we = 1'b0;
      skid_valid_in = 1'b0;
      state_d       = state_q;
      in_ready_d    = in_ready_q;

      if (Reset || flush) begin
         // Entries are cleared via entry_clear; any transfer is dropped.
         state_d    = StEmpty;
         in_ready_d = 1'b1;
      end else if (pre) begin
         // The incoming word is dropped; an out_xfer this cycle still completes.
         main_data_we  = 1'b1;
         main_data_in  = PresetValue;
         main_valid_we = 1'b1;
         main_valid_in = 1'b1;
         skid_valid_we = 1'b1;
         skid_valid_in = 1'b0;
         state_d       = StOne;
         in_ready_d    = 1'b1;
      end else if (advance) begin
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  main_data_we  = 1'b1;
                  main_valid_we = 1'b1;
                  main_valid_in = 1'b1;
                  state_d       = StOne;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  main_data_we = 1'b1;
               end else if (out_xfer) begin
                  main_valid_we = 1'b1;
                  main_valid_in = 1'b0;
                  state_d       = StEmpty;
               end else if (in_xfer) begin
                  skid_data_we  = 1'b1;
                  skid_valid_we = 1'b1;
                  skid_valid_in = 1'b1;
                  state_d       = StFull;
                  in_ready_d    = 1'b0;
               end
            end
            StFull: begin
               // in_ready is low here, so in_xfer cannot occur.
               if (out_xfer) begin
                  main_data_we  = 1'b1;
                  main_data_in  = skid_data;
                  skid_valid_we = 1'b1;
                  skid_valid_in = 1'b0;
                  state_d       = StOne;
                  in_ready_d    = 1'b1;
               end
            end
            default: begin
               state_d    = StEmpty;
               in_ready_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   pipe_entry_reg #(
      .NrOfBits   (NrOfBits),
      .ResetValue (ResetValue)
   ) u_main (
      .Clock    (Clock),
      .clear    (entry_clear),
      .data_we  (main_data_we),
      .data_in  (main_data_in),
      .valid_we (main_valid_we),
      .valid_in (main_valid_in),
      .data     (main_data),
      .valid    (main_valid)
   );

   pipe_entry_reg #(
      .NrOfBits   (NrOfBits),
      .ResetValue (ResetValue)
   ) u_skid (
      .Clock    (Clock),
      .clear    (entry_clear),
      .data_we  (skid_data_we),
      .data_in  (in_data),
      .valid_we (skid_valid_we),
      .valid_in (skid_valid_in),
      .data     (skid_data),
      .valid    (skid_valid)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid & ~cs;
   assign out_data  = cs ? '0 : main_data;
   assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_ex_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_ex_pipe_stage_skid
// Scoreboard bench: the driver keeps a queue model of the stage contents and
// pushes each accepted word into an expected-output queue; a separate monitor
// pops that queue whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_ex_pipe_stage_skid;

   localparam int unsigned W  = 32;
   localparam logic [W-1:0] RV = 32'h0BAD_F00D;
   localparam logic [W-1:0] PV = 32'hFFFF_FFFF;

   logic         Clock;
   logic         Reset, ClockEnable, Tick, flush, pre, cs;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_data, out_data;
   logic [1:0]   occupancy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mdl[$];    // current contents, head = word at the output
   logic [W-1:0] exp_q[$];  // words still owed to the downstream, in order
   bit           fresh_clear;

   ex_pipe_stage_skid #(
      .NrOfBits    (W),
      .ResetValue  (RV),
      .PresetValue (PV)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .ClockEnable (ClockEnable),
      .Tick        (Tick),
      .flush       (flush),
      .pre         (pre),
      .cs          (cs),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .occupancy   (occupancy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model, check state.
   task automatic step(input logic rst, input logic fl, input logic pr, input logic iv,
                       input logic [W-1:0] d, input logic ordy, input logic ce,
                       input logic tk, input logic c);
      bit ox, ix;
      @(negedge Clock);
      Reset = rst; flush = fl; pre = pr; in_valid = iv; in_data = d;
      out_ready = ordy; ClockEnable = ce; Tick = tk; cs = c;
      @(posedge Clock);
      #1;
      if (rst || fl) begin
         mdl.delete();
         exp_q.delete();
         fresh_clear = 1'b1;
      end else if (pr) begin
         mdl.delete();
         mdl.push_back(PV);
         exp_q.delete();
         exp_q.push_back(PV);
         fresh_clear = 1'b0;
      end else if (ce && tk) begin
         ox = !c && ordy && (mdl.size() > 0);
         ix = iv && (mdl.size() < 2);
         if (ox) void'(mdl.pop_front());
         if (ix) begin
            mdl.push_back(d);
            exp_q.push_back(d);
         end
         if (ox || ix) fresh_clear = 1'b0;
      end
      check("in_ready", W'(in_ready), W'(mdl.size() < 2));
      check("occupancy", W'(occupancy), W'(mdl.size()));
      check("out_valid", W'(out_valid), W'((mdl.size() > 0) && !c));
      if (c) check("out_data_cs", out_data, '0);
      else if (mdl.size() > 0) check("out_data_head", out_data, mdl[0]);
      else if (fresh_clear) check("out_data_reset", out_data, RV);
   endtask

   // Monitor: just before each edge, a completing output handshake must carry
   // the oldest owed word.
   initial begin
      forever begin
         @(negedge Clock);
         #2;
         if (!Reset && !flush && ClockEnable && Tick && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected: got %h, expected no output (t=%0t)", out_data, $time);
            end else begin
               check("out_order", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      Reset = 1'b1; flush = 1'b0; pre = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; ClockEnable = 1'b1; Tick = 1'b1; cs = 1'b0;
      fresh_clear = 1'b1;

      // Reset
      step(1, 0, 0, 0, '0, 0, 1, 1, 0);
      step(1, 0, 0, 0, '0, 0, 1, 1, 0);

      // Streaming with a ready sink
      step(0, 0, 0, 1, 32'h11, 1, 1, 1, 0);
      step(0, 0, 0, 1, 32'h22, 1, 1, 1, 0);
      step(0, 0, 0, 1, 32'h33, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      // Back-pressure fills both entries; a third word must be refused
      step(0, 0, 0, 1, 32'hA1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'hA2, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'hA3, 0, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      // Flush while full with a word offered: nothing survives
      step(0, 0, 0, 1, 32'hB1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'hB2, 0, 1, 1, 0);
      step(0, 1, 0, 1, 32'h55, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      // Preset, then preset together with flush
      step(0, 0, 1, 1, 32'h66, 0, 1, 1, 0);
      step(0, 1, 1, 0, '0, 0, 1, 1, 0);
      step(0, 0, 1, 0, '0, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      // Global stall while full, then output disabled
      step(0, 0, 0, 1, 32'hC1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'hC2, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'hC3, 1, 0, 1, 0);
      step(0, 0, 0, 1, 32'hC4, 1, 0, 1, 0);
      step(0, 0, 0, 1, 32'hC5, 1, 1, 0, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 1);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);
      step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(199) == 0), ($urandom_range(49) == 0),
              ($urandom_range(49) == 0), ($urandom_range(9) < 7), $urandom(),
              ($urandom_range(9) < 6), ($urandom_range(9) != 0),
              ($urandom_range(9) != 0), ($urandom_range(9) == 0));
      end

      // Drain
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 1, 1, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
